cpu0_intc: RTL and testbench
============================

# cpu0_intc

Interrupt controller for the cpu0 core. It collects the three peripheral interrupt lines (GPIO, UART, TIM1) and latches them as pending per source with programmable edge/level sensing and masking. It arbitrates by fixed priority and presents one request at a time on the core's `itype` input. It holds the request until the core acknowledges entry, then blocks further requests until end-of-interrupt (IRET). A small 4-word register window on the data bus gives software access to mask, pending, active and sense-mode state.

## Interface
Parameters:
- `NSRC`, 3: number of interrupt sources. Fixed order: bit0 GPIO, bit1 UART, bit2 TIM1.
- `RST_SENSE`, 3'b111: reset value of the SENSE register (1 = edge, 0 = level).

Ports:
- `clock` input 1: single clock. All state updates on the rising edge.
- `reset` input 1: asynchronous, active-high.
- `irq` input 3: raw interrupt lines, synchronous to `clock`, one bit per source.
- `ack` input 1: one-cycle pulse from core glue when the core takes the interrupt (core `tick==0`, `itype!=EXE`, `I==0`).
- `eoi` input 1: one-cycle pulse when the core executes IRET.
- `itype` output 4: interrupt code to the core. Values are EXE=0000, GPIO=0011, UART=0100, TIM1=0101.
- `active` output 3: one-hot source currently in service, or 0.
- `bus_en` input 1: register access strobe.
- `bus_rw` input 1: 1 = read, 0 = write.
- `bus_addr` input 2: register select.
- `bus_wdata` input 32: write data. Bits [2:0] are used; the rest are ignored.
- `bus_rdata` output 32: read data. Registered, zero-extended.

## Operation
- Registers:
  - 0 MASK: R/W, reset 0, 1 = enabled.
  - 1 PEND: read returns the pending bits; write-1-to-clear.
  - 2 ACTIVE: read-only.
  - 3 SENSE: R/W, reset `RST_SENSE`.
- Per-source pending bit:
  - Edge mode: set on a 0→1 transition of `irq[i]`, detected against a registered copy of `irq[i]`.
  - Level mode: set in any cycle where `irq[i]=1`.
  - Cleared by the `ack` that selects source i, or by a PEND write with bit i = 1.
- Same-cycle conflict on one source: a set (from edge or level) wins over a clear (from ack or W1C).
- Eligible set = PEND & MASK. Priority is fixed: GPIO > UART > TIM1.
- FSM states:
  - IDLE: `itype`=EXE. If the eligible set is non-empty, latch the highest-priority source into `sel` and go to ASSERT.
  - ASSERT: `itype` = code for `sel`. `sel` is locked; a higher-priority source arriving later does not preempt it.
    - On `ack`: clear PEND[sel], set `active`=onehot(sel), go to SERVICE.
    - If MASK[sel] is cleared or PEND[sel] is W1C-cleared before `ack`: go to IDLE (request withdrawn).
  - SERVICE: `itype`=EXE. New pending events are still latched. On `eoi`: `active`=0, go to IDLE.
- `ack` is ignored in IDLE and SERVICE. `eoi` is ignored in IDLE and ASSERT.
- `ack` and `eoi` asserted in the same cycle: only the one valid for the current state acts.
- Reset (any time, including mid-service): FSM=IDLE, `itype`=EXE, `active`=0, PEND=0, MASK=0, SENSE=`RST_SENSE`, `bus_rdata`=0, edge-detect registers=0.

## Timing
- `irq` edge sampled at edge n → PEND set after edge n → FSM in ASSERT and `itype` valid after edge n+1. Latency from input to request is 2 cycles.
- `ack` sampled at edge m → `itype`=EXE and `active` valid after edge m.
- `eoi` at edge k → IDLE after k. The earliest next `itype` is valid after k+1, giving at least one EXE cycle between services.
- Bus read: `bus_en && bus_rw` at edge r → `bus_rdata` valid after r and held until the next read.
- Bus write takes effect at the edge where it is sampled. A MASK write affects arbitration from the next cycle.
- `itype` is driven directly from a register: no combinational path from `irq`, `ack` or bus inputs.

## Structure
- Shared package `cpu0_pkg`:
  - itype codes (EXE, RESET, GPIO, UART, TIM1).
  - register offsets (MASK, PEND, ACTIVE, SENSE).
  - FSM state enum.
  - source index constants.
- Sub-module `intc_src`, instantiated `NSRC` times:
  - contains the edge detector, sense mux and pending flop;
  - inputs are set/clear controls, output is the pending bit.
- The top level holds the priority encoder, FSM, MASK/SENSE registers and bus decode.

## Test plan
- Reset mid-SERVICE:
  - Stimulus: enter SERVICE on UART, then assert `reset`.
  - Required: `itype`=0000, `active`=0, MASK=0 and PEND=0 immediately, without waiting for a clock.
- Edge GPIO:
  - Stimulus: MASK=3'b111; pulse `irq[0]` for one cycle.
  - Required: `itype`=0011 two cycles later and held until `ack`. After `ack`, `active`=001. After `eoi`, `active`=000.
- Simultaneous sources:
  - Stimulus: raise `irq[1]` and `irq[2]` together.
  - Required: UART (0100) is served first. After `eoi`, one EXE cycle, then `itype`=0101.
- Masked source:
  - Stimulus: MASK=3'b011; pulse `irq[2]`.
  - Required: PEND reads 3'b100 and `itype` stays EXE.
  - Then write MASK=3'b111: `itype`=0101 next cycle.
- Level source:
  - Stimulus: SENSE[0]=0; hold `irq[0]` high through `ack` and `eoi`.
  - Required: GPIO is re-requested after `eoi`.
  - Then drop `irq[0]` and W1C PEND=3'b001: no further request.
- Withdrawal:
  - Stimulus: while in ASSERT for TIM1, write MASK=3'b011.
  - Required: `itype`=EXE next cycle and FSM in IDLE. A subsequent `ack` is ignored and `active` stays 0.

Source files
------------

// File: rtl/cpu0_pkg.sv
// cpu0 interrupt controller shared definitions.
// itype codes, register map, FSM states, source indices.
package cpu0_pkg;

  localparam logic [3:0] ITYPE_EXE   = 4'b0000;
  localparam logic [3:0] ITYPE_RESET = 4'b0001;
  localparam logic [3:0] ITYPE_GPIO  = 4'b0011;
  localparam logic [3:0] ITYPE_UART  = 4'b0100;
  localparam logic [3:0] ITYPE_TIM1  = 4'b0101;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_PEND   = 2'd1;
  localparam logic [1:0] REG_ACTIVE = 2'd2;
  localparam logic [1:0] REG_SENSE  = 2'd3;

  localparam int SRC_GPIO = 0;
  localparam int SRC_UART = 1;
  localparam int SRC_TIM1 = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ASSERT,
    ST_SERVICE
  } intc_state_t;

  function automatic logic [3:0] src_code(input logic [1:0] idx);
    logic [3:0] code;
    code = ITYPE_EXE;
    unique case (idx)
      2'(SRC_GPIO): code = ITYPE_GPIO;
      2'(SRC_UART): code = ITYPE_UART;
      2'(SRC_TIM1): code = ITYPE_TIM1;
      default:      code = ITYPE_EXE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/intc_src.sv
// One interrupt source: edge detector, sense mux, pending flop.
// A set in the same cycle as a clear leaves the bit pending.
module intc_src (
  input  logic clock,
  input  logic reset,
  input  logic irq,
  input  logic sense,
  input  logic clr,
  output logic pend
);

  logic irq_q;
  logic set;

  assign set = sense ? (irq & ~irq_q) : irq;

  // Previous irq level for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) irq_q <= 1'b0;
    else       irq_q <= irq;
  end

  // Pending bit: set dominates clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) pend <= 1'b0;
    else       pend <= set | (pend & ~clr);
  end

endmodule

// File: rtl/cpu0_intc.sv
// cpu0 interrupt controller: pending/mask/sense registers,
// fixed-priority arbitration and the request/service FSM.
module cpu0_intc
  import cpu0_pkg::*;
#(
  parameter int              NSRC      = 3,
  parameter logic [NSRC-1:0] RST_SENSE = 3'b111
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] irq,
  input  logic            ack,
  input  logic            eoi,
  output logic [3:0]      itype,
  output logic [NSRC-1:0] active,
  input  logic            bus_en,
  input  logic            bus_rw,
  input  logic [1:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata
);

  localparam int SW = (NSRC > 1) ? $clog2(NSRC) : 1;

  intc_state_t     state;
  logic [SW-1:0]   sel;
  logic [SW-1:0]   pick;
  logic            any;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] sense;
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] elig;
  logic [NSRC-1:0] sel_oh;
  logic [NSRC-1:0] wd;
  logic [NSRC-1:0] clr;
  logic            wr;
  logic            wr_mask;
  logic            wr_pend;
  logic            wr_sense;
  logic            take;
  logic            withdraw;
  logic            unused_wdata;

  assign wd       = bus_wdata[NSRC-1:0];
  assign wr       = bus_en & ~bus_rw;
  assign wr_mask  = wr & (bus_addr == REG_MASK);
  assign wr_pend  = wr & (bus_addr == REG_PEND);
  assign wr_sense = wr & (bus_addr == REG_SENSE);

  assign unused_wdata = ^bus_wdata[31:NSRC];

  assign elig   = pend & mask;
  assign any    = |elig;
  assign sel_oh = {{(NSRC-1){1'b0}}, 1'b1} << sel;
  assign take   = (state == ST_ASSERT) & ack;

  // A request is dropped once its source stops being eligible,
  // or a bus write this cycle masks it or clears its pending bit.
  assign withdraw = ~|(elig & sel_oh)
                  | (wr_mask & ~|(wd & sel_oh))
                  | (wr_pend & |(wd & sel_oh));

  assign clr = (take ? sel_oh : '0) | (wr_pend ? wd : '0);

  // Fixed priority: lowest index wins
  always_comb begin
    pick = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (elig[i]) pick = SW'(i);
    end
  end

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    intc_src u_src (
      .clock (clock),
      .reset (reset),
      .irq   (irq[g]),
      .sense (sense[g]),
      .clr   (clr[g]),
      .pend  (pend[g])
    );
  end

  // MASK and SENSE registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mask  <= '0;
      sense <= RST_SENSE;
    end else begin
      if (wr_mask)  mask  <= wd;
      if (wr_sense) sense <= wd;
    end
  end

  // Registered read port, held between reads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus_rdata <= '0;
    end else if (bus_en && bus_rw) begin
      unique case (bus_addr)
        REG_MASK:   bus_rdata <= 32'(mask);
        REG_PEND:   bus_rdata <= 32'(pend);
        REG_ACTIVE: bus_rdata <= 32'(active);
        REG_SENSE:  bus_rdata <= 32'(sense);
        default:    bus_rdata <= '0;
      endcase
    end
  end

  // Request FSM with registered itype/active
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel    <= '0;
      itype  <= ITYPE_EXE;
      active <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            sel   <= pick;
            itype <= src_code(2'(pick));
            state <= ST_ASSERT;
          end
        end
        ST_ASSERT: begin
          if (ack) begin
            itype  <= ITYPE_EXE;
            active <= sel_oh;
            state  <= ST_SERVICE;
          end else if (withdraw) begin
            itype <= ITYPE_EXE;
            state <= ST_IDLE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            active <= '0;
            state  <= ST_IDLE;
          end
        end
        default: begin
          itype <= ITYPE_EXE;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu0_intc.sv
// Randomized and directed checks of cpu0_intc against
// a cycle-level behavioural model of the controller.
module tb_cpu0_intc;

  logic        clock;
  logic        reset;
  logic [2:0]  irq;
  logic        ack;
  logic        eoi;
  logic [3:0]  itype;
  logic [2:0]  active;
  logic        bus_en;
  logic        bus_rw;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;

  int n_vec;
  int n_err;

  // model state
  int          m_mode;
  int          m_src;
  bit          m_pend[3];
  bit          m_mask[3];
  bit          m_sense[3];
  bit          m_prev[3];
  logic [3:0]  m_itype;
  logic [2:0]  m_active;
  logic [31:0] m_rdata;

  cpu0_intc #(.NSRC(3), .RST_SENSE(3'b111)) dut (
    .clock     (clock),
    .reset     (reset),
    .irq       (irq),
    .ack       (ack),
    .eoi       (eoi),
    .itype     (itype),
    .active    (active),
    .bus_en    (bus_en),
    .bus_rw    (bus_rw),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [2:0] pack3(input bit b[3]);
    return {b[2], b[1], b[0]};
  endfunction

  task automatic model_reset();
    m_mode   = 0;
    m_src    = 0;
    m_itype  = 4'h0;
    m_active = 3'b000;
    m_rdata  = 32'h0;
    for (int i = 0; i < 3; i++) begin
      m_pend[i]  = 0;
      m_mask[i]  = 0;
      m_sense[i] = 1;
      m_prev[i]  = 0;
    end
  endtask

  // One clock edge of the controller, from the current inputs
  task automatic model_edge();
    bit   wr;
    bit   w_mask;
    bit   w_pend;
    bit   taken;
    bit   up;
    int   first;
    int   nmode;
    int   nsrc;
    logic [3:0] nit;
    logic [2:0] nact;
    wr     = bus_en && !bus_rw;
    w_mask = wr && bus_addr == 2'd0;
    w_pend = wr && bus_addr == 2'd1;
    taken  = 0;
    nmode  = m_mode;
    nsrc   = m_src;
    nit    = m_itype;
    nact   = m_active;
    if (m_mode == 0) begin
      first = -1;
      for (int i = 2; i >= 0; i--)
        if (m_pend[i] && m_mask[i]) first = i;
      if (first >= 0) begin
        nsrc  = first;
        nit   = 4'(3 + first);
        nmode = 1;
      end
    end else if (m_mode == 1) begin
      if (ack) begin
        taken = 1;
        nact  = 3'(1 << m_src);
        nit   = 4'h0;
        nmode = 2;
      end else if (!(m_pend[m_src] && m_mask[m_src])
                   || (w_mask && !bus_wdata[m_src])
                   || (w_pend && bus_wdata[m_src])) begin
        nit   = 4'h0;
        nmode = 0;
      end
    end else begin
      if (eoi) begin
        nact  = 3'b000;
        nmode = 0;
      end
    end
    if (bus_en && bus_rw) begin
      case (bus_addr)
        2'd0: m_rdata = 32'(pack3(m_mask));
        2'd1: m_rdata = 32'(pack3(m_pend));
        2'd2: m_rdata = 32'(m_active);
        default: m_rdata = 32'(pack3(m_sense));
      endcase
    end
    for (int i = 0; i < 3; i++) begin
      up = m_sense[i] ? (irq[i] && !m_prev[i]) : irq[i];
      if (up)
        m_pend[i] = 1;
      else if ((taken && m_src == i) || (w_pend && bus_wdata[i]))
        m_pend[i] = 0;
      m_prev[i] = irq[i];
    end
    for (int i = 0; i < 3; i++) begin
      if (w_mask) m_mask[i] = bus_wdata[i];
      if (wr && bus_addr == 2'd3) m_sense[i] = bus_wdata[i];
    end
    m_mode   = nmode;
    m_src    = nsrc;
    m_itype  = nit;
    m_active = nact;
  endtask

  task automatic tick(input logic [2:0] i_irq, input logic i_ack,
                      input logic i_eoi, input logic i_en,
                      input logic i_rw, input logic [1:0] i_addr,
                      input logic [31:0] i_wd);
    irq       = i_irq;
    ack       = i_ack;
    eoi       = i_eoi;
    bus_en    = i_en;
    bus_rw    = i_rw;
    bus_addr  = i_addr;
    bus_wdata = i_wd;
    @(posedge clock);
    model_edge();
    #1;
    check("itype", 32'(itype), 32'(m_itype));
    check("active", 32'(active), 32'(m_active));
    check("rdata", bus_rdata, m_rdata);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(3'b000, 0, 0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    tick(3'b000, 0, 0, 1, 0, a, d);
  endtask

  task automatic rd(input logic [1:0] a);
    tick(3'b000, 0, 0, 1, 1, a, 32'h0);
  endtask

  task automatic pulse(input logic [2:0] v);
    tick(v, 0, 0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic do_ack();
    tick(3'b000, 1, 0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic do_eoi();
    tick(3'b000, 0, 1, 0, 0, 2'd0, 32'h0);
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b1;
    irq       = 3'b000;
    ack       = 1'b0;
    eoi       = 1'b0;
    bus_en    = 1'b0;
    bus_rw    = 1'b0;
    bus_addr  = 2'd0;
    bus_wdata = 32'h0;
    model_reset();
    #1;
    check("rst_itype", 32'(itype), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_rdata", bus_rdata, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    rd(2'd3);
    check("sense_rst", bus_rdata, 32'h7);
    rd(2'd0);
    check("mask_rst", bus_rdata, 32'h0);

    // edge-triggered GPIO
    wr(2'd0, 32'h7);
    pulse(3'b001);
    check("gpio_lat1", 32'(itype), 32'h0);
    idle(1);
    check("gpio_req", 32'(itype), 32'h3);
    idle(3);
    check("gpio_hold", 32'(itype), 32'h3);
    do_ack();
    check("gpio_act", 32'(active), 32'h1);
    idle(2);
    do_eoi();
    check("gpio_eoi", 32'(active), 32'h0);
    idle(2);

    // UART and TIM1 together
    pulse(3'b110);
    idle(1);
    check("uart_first", 32'(itype), 32'h4);
    do_ack();
    check("uart_act", 32'(active), 32'h2);
    do_eoi();
    check("gap_exe", 32'(itype), 32'h0);
    idle(1);
    check("tim1_next", 32'(itype), 32'h5);
    do_ack();
    do_eoi();
    idle(2);

    // masked TIM1, then unmask
    wr(2'd0, 32'h3);
    pulse(3'b100);
    idle(2);
    check("masked_exe", 32'(itype), 32'h0);
    rd(2'd1);
    check("masked_pend", bus_rdata, 32'h4);
    wr(2'd0, 32'h7);
    idle(1);
    check("unmask_req", 32'(itype), 32'h5);
    do_ack();
    do_eoi();
    idle(2);

    // level-sensitive GPIO
    wr(2'd3, 32'h6);
    tick(3'b001, 0, 0, 0, 0, 2'd0, 32'h0);
    tick(3'b001, 0, 0, 0, 0, 2'd0, 32'h0);
    check("lvl_req", 32'(itype), 32'h3);
    tick(3'b001, 1, 0, 0, 0, 2'd0, 32'h0);
    tick(3'b001, 0, 0, 0, 0, 2'd0, 32'h0);
    tick(3'b001, 0, 1, 0, 0, 2'd0, 32'h0);
    tick(3'b001, 0, 0, 0, 0, 2'd0, 32'h0);
    check("lvl_rereq", 32'(itype), 32'h3);
    tick(3'b000, 0, 0, 1, 0, 2'd1, 32'h1);
    idle(3);
    check("lvl_gone", 32'(itype), 32'h0);
    rd(2'd1);
    check("lvl_pend", bus_rdata, 32'h0);
    wr(2'd3, 32'h7);

    // withdrawal by masking TIM1
    pulse(3'b100);
    idle(1);
    check("wd_req", 32'(itype), 32'h5);
    wr(2'd0, 32'h3);
    check("wd_exe", 32'(itype), 32'h0);
    do_ack();
    check("wd_noact", 32'(active), 32'h0);
    idle(2);
    wr(2'd1, 32'h4);
    wr(2'd0, 32'h7);
    idle(2);

    // reset in the middle of a UART service
    pulse(3'b010);
    idle(1);
    do_ack();
    check("svc_act", 32'(active), 32'h2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("mid_itype", 32'(itype), 32'h0);
    check("mid_active", 32'(active), 32'h0);
    check("mid_rdata", bus_rdata, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    rd(2'd0);
    check("mid_mask", bus_rdata, 32'h0);
    rd(2'd1);
    check("mid_pend", bus_rdata, 32'h0);

    // random traffic
    wr(2'd0, 32'h7);
    for (int n = 0; n < 600; n++) begin
      logic [2:0] r_irq;
      logic       r_ack;
      logic       r_eoi;
      logic       r_en;
      for (int b = 0; b < 3; b++) r_irq[b] = ($urandom_range(0, 4) == 0);
      r_ack = (itype != 4'h0) ? ($urandom_range(0, 2) == 0)
                              : ($urandom_range(0, 9) == 0);
      r_eoi = ($urandom_range(0, 4) == 0);
      r_en  = ($urandom_range(0, 3) == 0);
      tick(r_irq, r_ack, r_eoi, r_en, 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
